// File: rtl/lc3_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : lc3_mem_responder
// Brief    : Single-outstanding word memory responder for the LC3 fetch/load/
//            store path, with programmable read latency and range checking.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_mem_responder #(
  parameter int ADDR_W    = 8,
  parameter int LATENCY   = 2,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] addr_in,
  input  logic        wea_in,
  input  logic [15:0] wdata_in,
  output logic        busy,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        ack,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_wait_init = 4'(LATENCY - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wea;
  logic                r_err_pend;
  logic [15:0]         r_rdata;
  logic                r_rdata_valid;
  logic                r_ack;
  logic                r_err;
  logic [15:0]         r_mem [0:(2**ADDR_W)-1];

  logic                w_accept;
  logic                w_in_range;
  logic                w_go_resp;
  logic                w_resp_wr;
  logic                w_resp_err;
  logic [ADDR_W-1:0]   w_resp_addr;

  // rst gates acceptance so no write can slip into memory while held in reset
  assign w_accept    = req && !rst && (r_state != S_WAIT);
  assign w_in_range  = ((addr_in >> ADDR_W) == 16'd0);
  assign w_resp_wr   = w_accept ? wea_in : r_wea;
  assign w_resp_err  = w_accept ? ~w_in_range : r_err_pend;
  assign w_resp_addr = w_accept ? addr_in[ADDR_W-1:0] : r_addr;
  assign w_go_resp   = (w_state_nxt == S_RESP);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        if (w_accept) begin
          if (wea_in || (LATENCY == 1)) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_wait_init;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_addr        <= '0;
      r_wea         <= 1'b0;
      r_err_pend    <= 1'b0;
      r_rdata       <= 16'd0;
      r_rdata_valid <= 1'b0;
      r_ack         <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_addr     <= addr_in[ADDR_W-1:0];
        r_wea      <= wea_in;
        r_err_pend <= ~w_in_range;
      end
      r_rdata_valid <= w_go_resp & ~w_resp_wr;
      r_ack         <= w_go_resp & w_resp_wr;
      r_err         <= w_go_resp & w_resp_err;
      if (w_go_resp && !w_resp_wr) begin
        r_rdata <= w_resp_err ? 16'd0 : r_mem[w_resp_addr];
      end
    end
  end

  // Memory is deliberately outside the reset domain so contents survive rst
  always_ff @(posedge clk) begin
    if (w_accept && wea_in && w_in_range) begin
      r_mem[addr_in[ADDR_W-1:0]] <= wdata_in;
    end
  end

  assign busy        = (r_state == S_WAIT);
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign ack         = r_ack;
  assign err         = r_err;

endmodule
`default_nettype wire
